// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: out = in1 - in2, one bit per clock, LSB first,
// with valid/ready handshakes and registered borrow, signed-overflow and zero flags.
module serial_subtractor #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] in1_i,
    input  logic [N-1:0] in2_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] out_o,
    output logic         borrow_o,
    output logic         ovf_o,
    output logic         zero_o
);

    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d, r_q, r_d;
    logic            a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic            br_q, br_d, ovf_q, ovf_d, zero_q, zero_d;
    logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            diff_bit_s;
    logic [N-1:0]    r_shift_s;

    // Next-state, datapath and flag logic for the three-state sequencer.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        br_d        = br_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        cnt_d       = cnt_q;
        diff_bit_s  = a_q[0] ^ b_q[0] ^ br_q;
        r_shift_s   = {diff_bit_s, r_q[N-1:1]};

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = in1_i;
                    b_d     = in2_i;
                    a_msb_d = in1_i[N-1];
                    b_msb_d = in2_i[N-1];
                    br_d    = 1'b0;
                    r_d     = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
                r_d   = r_shift_s;
                a_d   = {1'b0, a_q[N-1:1]};
                b_d   = {1'b0, b_q[N-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                // Flags are settled on the final shift so DONE presents them from registers.
                if (cnt_q == CNT_LAST) begin
                    ovf_d   = (a_msb_q != b_msb_q) & (diff_bit_s != a_msb_q);
                    zero_d  = (r_shift_s == '0);
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            br_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            br_q        <= br_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_o       = r_q;
    assign borrow_o    = br_q;
    assign ovf_o       = ovf_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_w;
    logic         borrow;
    logic         ovf;
    logic         zero;

    int err_cnt = 0;
    int chk_cnt = 0;

    serial_subtractor #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in1_i       (in1),
        .in2_i       (in2),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_o       (out_w),
        .borrow_o    (borrow),
        .ovf_o       (ovf),
        .zero_o      (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        chk_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] d, output logic bw,
                         output logic ov, output logic z);
        longint sd;
        d  = a - b;
        bw = (a < b);
        sd = longint'($signed(a)) - longint'($signed(b));
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        z  = (d == '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},  {63'd0, in_ready},  64'd1);
        check_eq({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check_eq({tag, "_out"},       {32'd0, out_w},     64'd0);
        check_eq({tag, "_flags"},     {61'd0, borrow, ovf, zero}, 64'd0);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int hold, input bit keep_valid, input bit scramble);
        logic [N-1:0] ed;
        logic eb, eo, ez;
        int lat;
        model(a, b, ed, eb, eo, ez);
        @(negedge clk);
        in_valid = 1'b1;
        in1 = a;
        in2 = b;
        check_eq("ready_before_accept", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
        if (scramble) begin
            in1 = '0;
            in2 = '0;
        end
        check_eq("ready_drop", {63'd0, in_ready}, 64'd0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            if (!out_valid) lat++;
        end
        check_eq("latency", 64'(lat), 64'(N));
        check_eq("out",    {32'd0, out_w},  {32'd0, ed});
        check_eq("borrow", {63'd0, borrow}, {63'd0, eb});
        check_eq("ovf",    {63'd0, ovf},    {63'd0, eo});
        check_eq("zero",   {63'd0, zero},   {63'd0, ez});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
            check_eq("hold_ready", {63'd0, in_ready},  64'd0);
            check_eq("hold_out",   {29'd0, out_w, borrow, ovf, zero},
                                   {29'd0, ed, eb, eo, ez});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("release_valid", {63'd0, out_valid}, 64'd0);
        check_eq("release_ready", {63'd0, in_ready},  64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = '0;
        in2       = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h0000_0003, 32'h0000_0001, 0, 1'b0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 0, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        run_op(32'h1234_5678, 32'h1234_5678, 5, 1'b1, 1'b0);

        // Reset during the tenth shift cycle, then a fresh operation.
        @(negedge clk);
        in_valid = 1'b1;
        in1 = 32'h0000_000A;
        in2 = 32'h0000_0003;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h0000_0005, 32'h0000_0008, 0, 1'b0, 1'b0);

        run_op(32'h1234_5678, 32'h8765_4321, 0, 1'b0, 1'b1);

        for (int k = 0; k < 20; k++) begin
            run_op($urandom, $urandom, int'($urandom_range(0, 2)), 1'b0, k[0]);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
